// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master and its phase generator.
//   - Default system / SCL frequencies
//   - ACK / NACK bus levels
//   - Quarter-bit phase encoding (Q0..Q3)
//   - Master transaction state encoding
package i2c_pkg;

  localparam int DEF_SYS_FREQ = 4_000_000;
  localparam int DEF_I2C_FREQ = 100_000;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_t;

  typedef enum logic [3:0] {
    IDLE        = 4'd0,
    START       = 4'd1,
    WRITE_ADDR  = 4'd2,
    ADDR_ACK    = 4'd3,
    WRITE_DATA  = 4'd4,
    DATA_ACK    = 4'd5,
    READ_DATA   = 4'd6,
    MASTER_NACK = 4'd7,
    STOP        = 4'd8
  } state_t;

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-bit phase generator. While en is high it counts CLK_COUNT1 clocks
// per quarter and steps the quarter index Q0->Q1->Q2->Q3->Q0. While en is low
// the counter and quarter index are held at zero, so enabling it starts a bit
// cleanly at the first cycle of Q0.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset
//   en       count enable
//   quarter  current quarter of the bit
//   q_first  first clock cycle of the current quarter
//   q_last   last clock cycle of the current quarter
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int CLK_COUNT1 = 10
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     en,
  output quarter_t quarter,
  output logic     q_first,
  output logic     q_last
);

  localparam int CW = (CLK_COUNT1 > 1) ? $clog2(CLK_COUNT1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_COUNT1 - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (!en) begin
      cnt     <= '0;
      quarter <= Q0;
    end else if (cnt == CNT_LAST) begin
      cnt     <= '0;
      quarter <= quarter_t'(quarter + 2'd1);
    end else begin
      cnt     <= cnt + CW'(1);
    end
  end

  assign q_first = en && (cnt == '0);
  assign q_last  = en && (cnt == CNT_LAST);

endmodule

// File: rtl/i2c_master.sv
// Single-master I2C controller issuing one-byte register transactions:
// START, 7-bit address + R/W, address ACK, one data byte (written or read),
// data ACK (write) or master NACK (read), STOP.
// Bit timing: four quarters per bit; SCL low in Q0-Q1, high in Q2-Q3.
// Outputs are registered on the last cycle of the preceding quarter so that
// SDA changes land on the first cycle of Q1 and SCL edges land on quarter
// boundaries. SDA is sampled on the last cycle of Q2.
// Ports:
//   clk      system clock
//   rst      asynchronous active-low reset (aborts with no STOP)
//   newd     start-request strobe, honoured only in IDLE
//   op       0 = write, 1 = read (sent as the R/W bit)
//   addr     7-bit target address
//   din      write data
//   scl      I2C clock, push-pull
//   sda      I2C data, open-drain (drives 0 or z)
//   dout     last byte successfully read
//   busy     transaction in progress
//   ack_err  NACK seen during the last transaction
//   done     one-cycle completion pulse, coincident with busy falling
module i2c_master
  import i2c_pkg::*;
#(
  parameter int SYS_FREQ   = DEF_SYS_FREQ,
  parameter int I2C_FREQ   = DEF_I2C_FREQ,
  parameter int CLK_COUNT1 = SYS_FREQ / I2C_FREQ / 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       newd,
  input  logic       op,
  input  logic [6:0] addr,
  input  logic [7:0] din,
  output logic       scl,
  inout  wire        sda,
  output logic [7:0] dout,
  output logic       busy,
  output logic       ack_err,
  output logic       done
);

  state_t     state;
  quarter_t   quarter;
  logic       q_first;
  logic       q_last;
  logic [3:0] bit_cnt;
  logic       sda_oe;
  logic       rx_bit;
  logic [6:0] addr_r;
  logic       op_r;
  logic [7:0] din_r;
  logic [7:0] rx_sh;
  logic [7:0] tx_byte;
  logic       tx_bit;
  logic       last_bit;
  logic       accept;
  logic       rd_sample;

  i2c_phase_gen #(
    .CLK_COUNT1(CLK_COUNT1)
  ) u_phase (
    .clk    (clk),
    .rst    (rst),
    .en     (busy),
    .quarter(quarter),
    .q_first(q_first),
    .q_last (q_last)
  );

  assign sda = sda_oe ? 1'b0 : 1'bz;

  assign accept    = (state == IDLE) && newd;
  assign rd_sample = q_last && (quarter == Q2) && (state == READ_DATA);
  assign tx_byte   = (state == WRITE_ADDR) ? {addr_r, op_r} : din_r;
  assign tx_bit    = tx_byte[3'd7 - bit_cnt[2:0]];
  assign last_bit  = (bit_cnt == 4'd7);

  // Request capture and receive shift register (data path, no reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_r <= addr;
      op_r   <= op;
      din_r  <= din;
    end
    if (rd_sample) begin
      rx_sh <= {rx_sh[6:0], sda};
    end
  end

  // Transaction FSM with registered bus and host outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      scl     <= 1'b1;
      sda_oe  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      dout    <= '0;
      rx_bit  <= NACK;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        scl    <= 1'b1;
        sda_oe <= 1'b0;
        if (accept) begin
          busy    <= 1'b1;
          ack_err <= 1'b0;
          bit_cnt <= '0;
          state   <= START;
        end
      end else if (q_last) begin
        unique case (quarter)
          // End of Q0: present the data bit; STOP raises SCL here instead
          Q0: begin
            if (state == STOP) begin
              scl <= 1'b1;
            end else if (state == WRITE_ADDR || state == WRITE_DATA) begin
              sda_oe <= ~tx_bit;
            end else if (state != START) begin
              sda_oe <= 1'b0;
            end
          end
          // End of Q1: raise SCL; START pulls SDA low, STOP releases it
          Q1: begin
            if (state == START) begin
              sda_oe <= 1'b1;
            end else if (state == STOP) begin
              sda_oe <= 1'b0;
            end else begin
              scl <= 1'b1;
            end
          end
          // End of Q2: sample SDA while SCL is high
          Q2: begin
            rx_bit <= sda;
          end
          // End of Q3: bit boundary, SCL falls unless the transaction ends.
          // Ack states pre-drive SDA low so STOP's Q0 already holds it at 0.
          Q3: begin
            scl     <= 1'b0;
            bit_cnt <= bit_cnt + 4'd1;
            case (state)
              START: begin
                bit_cnt <= '0;
                state   <= WRITE_ADDR;
              end
              WRITE_ADDR: begin
                if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= ADDR_ACK;
                end
              end
              ADDR_ACK: begin
                bit_cnt <= '0;
                if (rx_bit == NACK) begin
                  ack_err <= 1'b1;
                  sda_oe  <= 1'b1;
                  state   <= STOP;
                end else begin
                  state <= op_r ? READ_DATA : WRITE_DATA;
                end
              end
              WRITE_DATA: begin
                if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= DATA_ACK;
                end
              end
              DATA_ACK: begin
                bit_cnt <= '0;
                if (rx_bit != ACK) begin
                  ack_err <= 1'b1;
                end
                sda_oe <= 1'b1;
                state  <= STOP;
              end
              READ_DATA: begin
                if (last_bit) begin
                  bit_cnt <= '0;
                  state   <= MASTER_NACK;
                end
              end
              MASTER_NACK: begin
                bit_cnt <= '0;
                dout    <= rx_sh;
                sda_oe  <= 1'b1;
                state   <= STOP;
              end
              STOP: begin
                bit_cnt <= '0;
                scl     <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                state   <= IDLE;
              end
              default: begin
                bit_cnt <= '0;
                state   <= IDLE;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_master.sv
// Self-checking bench for i2c_master: a behavioural I2C register slave on
// the bus, a reference register map and expected-latency arithmetic in the
// bench, randomized transactions plus directed boundary cases.
module tb_i2c_master;

  localparam int C        = 4000000 / 100000 / 4;
  localparam int LAT_FULL = 20 * 4 * C;
  localparam int LAT_NACK = 11 * 4 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       newd;
  logic       op;
  logic [6:0] addr;
  logic [7:0] din;
  logic       scl;
  wire        sda;
  logic [7:0] dout;
  logic       busy;
  logic       ack_err;
  logic       done;

  int n_tests = 0;
  int n_fail  = 0;

  // bench-controlled slave behaviour
  bit slave_en  = 1'b1;
  bit data_nack = 1'b0;

  // reference model state
  logic [7:0] ref_mem [128];
  bit         ref_valid [128];
  logic [7:0] ref_dout;

  always #5 clk = ~clk;

  i2c_master dut (
    .clk    (clk),
    .rst    (rst),
    .newd   (newd),
    .op     (op),
    .addr   (addr),
    .din    (din),
    .scl    (scl),
    .sda    (sda),
    .dout   (dout),
    .busy   (busy),
    .ack_err(ack_err),
    .done   (done)
  );

  // ---------------- behavioural slave + bus monitor ----------------
  logic         s_drive    = 1'b0;
  logic         s_prev_scl = 1'b1;
  logic         s_prev_sda = 1'b1;
  int           s_phase    = 0;
  int           s_cnt      = 0;
  logic [7:0]   s_sh       = '0;
  logic [7:0]   s_tx       = '0;
  logic [6:0]   s_addr     = '0;
  logic         s_rw       = 1'b0;
  logic [7:0]   smem [128];
  logic [127:0] s_valid    = '0;
  int           s_starts   = 0;
  int           s_stops    = 0;
  int           s_nrise    = 0;
  int           s_last_rise = 0;
  int           s_period   = 0;
  int           cyc        = 0;
  logic [7:0]   s_rd;

  pullup (sda);
  assign sda  = s_drive ? 1'b0 : 1'bz;
  assign s_rd = s_valid[s_addr] ? smem[s_addr] : {1'b0, s_addr};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      s_phase    <= 0;
      s_drive    <= 1'b0;
      s_prev_scl <= 1'b1;
      s_prev_sda <= 1'b1;
    end else begin
      s_prev_scl <= scl;
      s_prev_sda <= sda;
      if (s_prev_scl && scl && s_prev_sda && !sda) begin
        s_starts <= s_starts + 1;
        s_phase  <= 1;
        s_cnt    <= 0;
        s_sh     <= '0;
        s_nrise  <= 0;
      end else if (s_prev_scl && scl && !s_prev_sda && sda) begin
        s_stops <= s_stops + 1;
        s_phase <= 0;
        s_drive <= 1'b0;
      end else if (!s_prev_scl && scl) begin
        if (s_nrise == 1) s_period <= cyc - s_last_rise;
        s_last_rise <= cyc;
        s_nrise     <= s_nrise + 1;
        if (s_phase == 1 || s_phase == 3) begin
          s_sh  <= {s_sh[6:0], sda};
          s_cnt <= s_cnt + 1;
        end
      end else if (s_prev_scl && !scl) begin
        case (s_phase)
          1: if (s_cnt == 8) begin
               s_addr <= s_sh[7:1];
               s_rw   <= s_sh[0];
               if (slave_en) begin
                 s_drive <= 1'b1;
                 s_phase <= 2;
               end else begin
                 s_phase <= 0;
               end
             end
          2: if (s_rw) begin
               s_tx    <= s_rd;
               s_drive <= ~s_rd[7];
               s_cnt   <= 1;
               s_phase <= 5;
             end else begin
               s_drive <= 1'b0;
               s_cnt   <= 0;
               s_sh    <= '0;
               s_phase <= 3;
             end
          3: if (s_cnt == 8) begin
               if (!data_nack) begin
                 smem[s_addr]    <= s_sh;
                 s_valid[s_addr] <= 1'b1;
                 s_drive         <= 1'b1;
               end
               s_phase <= 4;
             end
          4: begin
               s_drive <= 1'b0;
               s_phase <= 0;
             end
          5: if (s_cnt == 8) begin
               s_drive <= 1'b0;
               s_phase <= 6;
             end else begin
               s_drive <= ~s_tx[3'(7 - s_cnt)];
               s_cnt   <= s_cnt + 1;
             end
          6: s_phase <= 0;
          default: s_phase <= 0;
        endcase
      end
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic sda_released();
    return (sda === 1'b0) ? 1'b0 : 1'b1;
  endfunction

  task automatic xfer(input logic o, input logic [6:0] a, input logic [7:0] d, input bit inject);
    int         n;
    int         st0;
    int         sp0;
    int         extra;
    logic [7:0] exp_dout;
    logic       exp_err;
    int         exp_lat;

    exp_err  = !slave_en || (!o && data_nack);
    exp_lat  = slave_en ? LAT_FULL : LAT_NACK;
    exp_dout = ref_dout;
    if (slave_en) begin
      if (o) exp_dout = ref_valid[a] ? ref_mem[a] : {1'b0, a};
      else if (!data_nack) begin
        ref_mem[a]   = d;
        ref_valid[a] = 1'b1;
      end
    end
    ref_dout = exp_dout;

    st0 = s_starts;
    sp0 = s_stops;
    @(negedge clk);
    newd = 1'b1; op = o; addr = a; din = d;
    @(posedge clk); #1;
    newd = 1'b0; op = ~o; addr = 7'($urandom); din = 8'($urandom);
    check("accept_busy", {31'b0, busy}, 1);
    check("accept_ack_err_clear", {31'b0, ack_err}, 0);

    n = 0;
    while (!done && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (inject && n == 100) begin
        newd = 1'b1; addr = 7'h7F; op = ~o; din = 8'($urandom);
      end
      if (inject && n == 102) newd = 1'b0;
    end
    check("latency", n, exp_lat);
    check("done_busy_low", {31'b0, busy}, 0);
    check("ack_err", {31'b0, ack_err}, {31'b0, exp_err});
    check("dout", {24'b0, dout}, {24'b0, exp_dout});
    check("start_count", s_starts - st0, 1);
    check("stop_count", s_stops - sp0, 1);
    check("scl_period", s_period, 4 * C);
    check("idle_sda_released", {31'b0, sda_released()}, 1);
    check("idle_scl_high", {31'b0, scl}, 1);

    extra = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    check("single_done", extra, 0);
  endtask

  initial begin
    rst = 1'b0; newd = 1'b0; op = 1'b0; addr = '0; din = '0;
    for (int i = 0; i < 128; i++) begin
      ref_mem[i]   = 8'h00;
      ref_valid[i] = 1'b0;
    end
    ref_dout = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("rst_scl", {31'b0, scl}, 1);
    check("rst_sda", {31'b0, sda_released()}, 1);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ack_err", {31'b0, ack_err}, 0);
    check("rst_dout", {24'b0, dout}, 0);
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);

    // read of default register contents
    xfer(1'b1, 7'h15, 8'h00, 1'b0);
    // write then read back
    xfer(1'b0, 7'h2A, 8'hC3, 1'b0);
    xfer(1'b1, 7'h2A, 8'h00, 1'b0);
    // address NACK: dout must hold 0xC3
    slave_en = 1'b0;
    xfer(1'b1, 7'h2A, 8'h00, 1'b0);
    slave_en = 1'b1;
    // newd while busy with addr 0x7F is ignored
    xfer(1'b0, 7'h33, 8'h5A, 1'b1);
    xfer(1'b1, 7'h33, 8'h00, 1'b0);
    xfer(1'b1, 7'h7F, 8'h00, 1'b0);
    // data NACK on write: ack_err set, register unchanged
    data_nack = 1'b1;
    xfer(1'b0, 7'h33, 8'hA5, 1'b0);
    data_nack = 1'b0;
    xfer(1'b1, 7'h33, 8'h00, 1'b0);

    // randomized transactions
    for (int k = 0; k < 10; k++) begin
      slave_en  = ($urandom_range(0, 4) != 0);
      data_nack = ($urandom_range(0, 5) == 0);
      xfer(1'($urandom), 7'($urandom), 8'($urandom), 1'b0);
    end
    slave_en  = 1'b1;
    data_nack = 1'b0;

    // asynchronous reset in the middle of WRITE_DATA
    @(negedge clk);
    newd = 1'b1; op = 1'b0; addr = 7'h44; din = 8'h96;
    @(posedge clk); #1;
    newd = 1'b0;
    repeat (12 * 4 * C) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("arst_scl", {31'b0, scl}, 1);
    check("arst_sda", {31'b0, sda_released()}, 1);
    check("arst_busy", {31'b0, busy}, 0);
    check("arst_done", {31'b0, done}, 0);
    check("arst_dout", {24'b0, dout}, 0);
    ref_dout = 8'h00;
    @(negedge clk); rst = 1'b1;
    repeat (5) @(posedge clk);
    // aborted write never reached the register
    xfer(1'b1, 7'h44, 8'h00, 1'b0);
    xfer(1'b0, 7'h44, 8'h3C, 1'b0);
    xfer(1'b1, 7'h44, 8'h00, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_master.md
Name: i2c_master

Overview:
- Single-master I2C controller: the upstream stage that drives i2c_Slave's scl/sda and issues one-byte register transactions.
- Each transaction is a 7-bit address, one R/W bit and one data byte.
- Host side is a simple newd/busy/done handshake.
- Generates SCL with the same 4-quarter bit timing the slave tracks: open-drain SDA, START, address+R/W, ACK checks, one data byte, STOP.

Parameters:
- SYS_FREQ, 4000000, system clock frequency in Hz.
- I2C_FREQ, 100000, SCL frequency in Hz.
- CLK_COUNT1, SYS_FREQ/I2C_FREQ/4 (=10), clk cycles per quarter bit. Must be >= 2.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- newd  in  1  start-request strobe from host.
- op  in  1  0 = write, 1 = read; sent as the R/W bit.
- addr  in  7  target address.
- din  in  8  write data.
- scl  out  1  I2C clock, push-pull.
- sda  inout  1  I2C data, open-drain: drives 0 or z.
- dout  out  8  last byte read.
- busy  out  1  transaction in progress.
- ack_err  out  1  NACK seen in the last transaction.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async):
  - scl=1, sda released, busy=0, done=0, ack_err=0, dout=0.
  - State IDLE, phase counter cleared.
  - Mid-transaction reset aborts immediately with no STOP generated.
- Phase timing: each bit = 4 quarters (q0..q3) of CLK_COUNT1 cycles each.
  - SCL is low in q0–q1 and high in q2–q3.
  - SDA changes only on the first cycle of q1.
  - SDA is sampled on the last cycle of q2.
  - Phase counter runs only while busy; it restarts at q0 on accept.
- Handshake:
  - In IDLE, newd=1 latches addr/op/din, sets busy=1 and clears ack_err, then goes to START.
  - newd while busy is ignored.
  - done pulses for 1 cycle when busy falls, on the same edge.
- States:
  - IDLE: scl=1, sda released.
  - START (1 bit): scl=1 throughout; sda released q0–q1, driven 0 q2–q3.
  - WRITE_ADDR (8 bits): shift {addr,op} MSB first.
  - ADDR_ACK (1 bit): release sda and sample. 1 -> ack_err=1, go to STOP. 0 -> op=0 goes to WRITE_DATA, op=1 goes to READ_DATA.
  - WRITE_DATA (8 bits): din MSB first.
  - DATA_ACK (1 bit): sample. 1 -> ack_err=1. Always goes to STOP.
  - READ_DATA (8 bits): sda released; shift sampled bits into a shift register MSB first.
  - MASTER_NACK (1 bit): sda released (NACK); dout <= shift register at the end of the bit.
  - STOP (1 bit): sda 0 in q0–q1; scl low q0, high q1–q3; sda released q2–q3. Then busy=0, done=1, go to IDLE.
- Latency:
  - Full write or read = 20 bit times = 80*CLK_COUNT1 cycles (800 at defaults) from accept to done.
  - Address NACK = 11 bit times (440 cycles).
- Bit counter is 4 bits and resets to 0 on every state change; there is no wrap beyond 8.
- dout holds its value until the next successful read; it is not updated on an address NACK.
- ack_err holds its value until the next accept.

Decomposition:
- Package i2c_pkg holds:
  - state enum;
  - quarter-phase encoding (Q0..Q3);
  - ACK=0 / NACK=1 constants;
  - default SYS_FREQ/I2C_FREQ.
- Sub-module i2c_phase_gen (counter + 2-bit quarter index + first/last-cycle strobes, enable input) is natural and reusable by the slave.

Test Plan:
- Read from slave, addr=0x15 after reset -> dout=0x15, ack_err=0, done exactly 800 cycles after newd, SCL period 40 clk.
- Write addr=0x2A din=0xC3, then read addr=0x2A -> second dout=0xC3, ack_err=0 both times.
- Address NACK (bench holds sda released) -> ack_err=1, STOP seen (sda rises while scl=1), done at 440 cycles, dout unchanged.
- newd re-asserted at cycle 100 of a transaction with addr=0x7F -> ignored; one done only, latched address is the original.
- Protocol checker throughout: SDA never changes while SCL=1 except at START (falling) and STOP (rising).
- rst=0 asynchronously mid-WRITE_DATA -> scl=1, sda=z, busy=0 with no clk edge; next newd runs a clean transaction.
